yarp_mem_arbiter: RTL
=====================

YARP_MEM_ARBITER -- requirements
Module: yarp_mem_arbiter

Interface
REQ-001 SHALL have parameters: none; all widths fixed (32-bit address/data, 2-bit core size code, 4-bit bus strobe).
REQ-002 clk  in  1  clock; all state on posedge clk.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 if_req_i  in  1 / if_addr_i  in  32  instruction-fetch request and address from the core.
REQ-005 if_rvalid_o  out  1 / if_rdata_o  out  32  fetch response pulse and instruction word.
REQ-006 d_req_i  in  1 / d_addr_i  in  32 / d_wr_i  in  1  data request, address, write flag.
REQ-007 d_byte_en_i  in  2 / d_wdata_i  in  32  size code (yarp_pkg BYTE/HALF/WORD) and store data (low-aligned).
REQ-008 d_rvalid_o  out  1 / d_rdata_o  out  32 / d_misalign_o  out  1  data completion pulse, low-aligned load data, misalignment pulse.
REQ-009 stall_o  out  1  core must hold PC/state while high.
REQ-010 bus_req_o  out  1 / bus_addr_o  out  32 / bus_wr_o  out  1 / bus_be_o  out  4 / bus_wdata_o  out  32  shared memory port request.
REQ-011 bus_gnt_i  in  1 / bus_rvalid_i  in  1 / bus_rdata_i  in  32  bus accept, completion (reads and writes), read data.

Function
REQ-012 SHALL use FSM ARB_IDLE -> ARB_REQ -> ARB_RSP -> ARB_DONE -> ARB_IDLE; one transaction outstanding max.
REQ-013 In ARB_IDLE, if any request is high, SHALL select one port, latch its address/size/wr/wdata/port-id at the clock edge, and enter ARB_REQ; with no request, SHALL stay in ARB_IDLE.
REQ-014 Without YARP_ARB_RR_EN, on simultaneous if_req_i and d_req_i the data port SHALL win.
REQ-015 In ARB_REQ, bus_req_o SHALL be 1 with latched fields stable until the cycle bus_gnt_i=1, then SHALL go to ARB_RSP; bus_req_o SHALL be 0 in every other state.
REQ-016 In ARB_RSP, on bus_rvalid_i=1 SHALL register bus_rdata_i and enter ARB_DONE; bus_rvalid_i in other states SHALL be ignored.
REQ-017 In ARB_DONE, the granted port's *_rvalid_o SHALL be 1 for exactly one cycle; the other port's rvalid SHALL be 0; requests SHALL NOT be sampled in ARB_DONE.
REQ-018 Minimum latency: request at cycle 0, bus_req_o cycle 1, gnt cycle 1, bus_rvalid_i cycle 2, *_rvalid_o cycle 3.
REQ-019 bus_be_o SHALL be: BYTE 4'b0001<<a[1:0]; HALF 4'b0011<<a[1:0]; WORD 4'b1111; fetch reads 4'b1111.
REQ-020 bus_wdata_o SHALL replicate d_wdata_i[7:0] x4 (BYTE), d_wdata_i[15:0] x2 (HALF), or pass through (WORD).
REQ-021 d_rdata_o SHALL equal registered bus data shifted right by 8*a[1:0], zero-filled; if_rdata_o unshifted; bus_addr_o SHALL carry the full request address with a[1:0] forced to 0.
REQ-022 A HALF with a[0]=1 or WORD with a[1:0]!=0 SHALL skip the bus (IDLE -> DONE directly), assert d_misalign_o and d_rvalid_o together for one cycle, d_rdata_o=0.
REQ-023 stall_o SHALL be combinational: (if_req_i & !if_rvalid_o) | (d_req_i & !d_rvalid_o).
REQ-024 if_rdata_o/d_rdata_o SHALL hold their last value outside ARB_DONE.

Reset
REQ-025 On reset_n=0 asynchronously: state ARB_IDLE; bus_req_o, if_rvalid_o, d_rvalid_o, d_misalign_o 0; rdata, latched fields 0; RR pointer = instruction port last granted.
REQ-026 Reset during ARB_REQ/ARB_RSP SHALL abandon the transaction; no response SHALL be delivered for it.

Configuration
REQ-027 Macro YARP_ARB_RR_EN: defined -> on simultaneous requests grant the port not granted last, pointer updated on each grant; undefined -> fixed data priority (REQ-014), no pointer flop.

Structure
REQ-028 yarp_pkg SHALL hold the arb_state_t enum, port-id enum, and reuse existing BYTE/HALF/WORD size constants.
REQ-029 SHALL instantiate one sub-module yarp_strb_gen (size + a[1:0] -> bus_be_o, bus_wdata_o, misalign flag), purely combinational.

Verification
REQ-030 Fetch 0x1000, gnt same cycle, rvalid next with 0x00500093 -> if_rvalid_o cycle 3, if_rdata_o=0x00500093, stall_o 1 cycles 0-2.
REQ-031 Simultaneous fetch 0x1004 and load word 0x2000 -> data first; with YARP_ARB_RR_EN, second simultaneous pair -> fetch first.
REQ-032 Store BYTE 0xAB to 0x2003 -> bus_be_o=4'b1000, bus_wdata_o=0xABABABAB, bus_wr_o=1.
REQ-033 Load HALF 0x2002, bus_rdata_i=0xBEEF1234 -> d_rdata_o=0x0000BEEF.
REQ-034 Load WORD 0x2001 -> no bus_req_o, d_misalign_o=d_rvalid_o=1 one cycle, d_rdata_o=0.
REQ-035 bus_gnt_i held 0 for 5 cycles then reset_n pulsed in ARB_RSP -> bus_req_o stable 5 cycles; after reset no rvalid, state ARB_IDLE.

Source files
------------

// File: rtl/yarp_pkg.sv
// Shared types for the YARP memory arbiter: core access-size codes,
// arbiter FSM states and requesting-port identifiers.
package yarp_pkg;

  localparam logic [1:0] BYTE = 2'b00;
  localparam logic [1:0] HALF = 2'b01;
  localparam logic [1:0] WORD = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_REQ  = 2'b01,
    ARB_RSP  = 2'b10,
    ARB_DONE = 2'b11
  } arb_state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_id_t;

endpackage

// File: rtl/yarp_strb_gen.sv
// Combinational byte-lane generator: access size + address low bits ->
// bus byte enables, lane-replicated store data and misalignment flag.
module yarp_strb_gen
  import yarp_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] bus_wdata,
  output logic        misalign
);

  always_comb begin
    be        = 4'b1111;
    bus_wdata = wdata;
    misalign  = 1'b0;
    case (size)
      BYTE: begin
        be        = 4'b0001 << addr_lo;
        bus_wdata = {4{wdata[7:0]}};
      end
      HALF: begin
        be        = 4'b0011 << addr_lo;
        bus_wdata = {2{wdata[15:0]}};
        misalign  = addr_lo[0];
      end
      default: begin
        misalign  = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/yarp_mem_arbiter.sv
// Arbitrates the YARP fetch and data ports onto one memory bus, one transaction
// in flight. Define YARP_ARB_RR_EN for round-robin; default is fixed data priority.
module yarp_mem_arbiter
  import yarp_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic [31:0] d_addr_i,
  input  logic        d_wr_i,
  input  logic [1:0]  d_byte_en_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        d_misalign_o,
  output logic        stall_o,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  output logic        bus_wr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  arb_state_t  state_q, state_d;
  logic        any_req, sel_d, sel_wr, req_mis;
  logic [31:0] sel_addr;
  logic [1:0]  sel_size;
  logic [3:0]  sg_be;
  logic [31:0] sg_wdata;
  logic        sg_mis;

  logic [31:0] addr_q, wdata_q, if_rdata_q, d_rdata_q;
  logic [3:0]  be_q;
  logic        wr_q, mis_q;
  port_id_t    port_q;

  assign any_req = if_req_i | d_req_i;

`ifdef YARP_ARB_RR_EN
  port_id_t last_q;

  // On contention the port not served last wins; a lone request always wins.
  assign sel_d = d_req_i & (~if_req_i | (last_q == PORT_IF));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= PORT_IF;
    end else if (state_q == ARB_IDLE && any_req) begin
      last_q <= sel_d ? PORT_D : PORT_IF;
    end
  end
`else
  assign sel_d = d_req_i;
`endif

  assign sel_addr = sel_d ? d_addr_i : if_addr_i;
  assign sel_size = sel_d ? d_byte_en_i : WORD;
  assign sel_wr   = sel_d & d_wr_i;
  // Fetches are always full-word reads; only data accesses can be misaligned.
  assign req_mis  = sel_d & sg_mis;

  yarp_strb_gen u_strb_gen (
    .size      (sel_size),
    .addr_lo   (sel_addr[1:0]),
    .wdata     (d_wdata_i),
    .be        (sg_be),
    .bus_wdata (sg_wdata),
    .misalign  (sg_mis)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bus_req_o    = 1'b0;
    if_rvalid_o  = 1'b0;
    d_rvalid_o   = 1'b0;
    d_misalign_o = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) state_d = req_mis ? ARB_DONE : ARB_REQ;
      end
      ARB_REQ: begin
        bus_req_o = 1'b1;
        if (bus_gnt_i) state_d = ARB_RSP;
      end
      ARB_RSP: begin
        if (bus_rvalid_i) state_d = ARB_DONE;
      end
      ARB_DONE: begin
        if_rvalid_o  = (port_q == PORT_IF);
        d_rvalid_o   = (port_q == PORT_D);
        d_misalign_o = mis_q;
        state_d      = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      wr_q       <= 1'b0;
      mis_q      <= 1'b0;
      port_q     <= PORT_IF;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (state_q == ARB_IDLE && any_req) begin
        addr_q  <= sel_addr;
        wdata_q <= sg_wdata;
        be_q    <= sg_be;
        wr_q    <= sel_wr;
        mis_q   <= req_mis;
        port_q  <= sel_d ? PORT_D : PORT_IF;
        if (req_mis) d_rdata_q <= '0;
      end
      if (state_q == ARB_RSP && bus_rvalid_i) begin
        if (port_q == PORT_IF) begin
          if_rdata_q <= bus_rdata_i;
        end else begin
          d_rdata_q  <= bus_rdata_i >> {addr_q[1:0], 3'b000};
        end
      end
    end
  end

  assign bus_addr_o  = {addr_q[31:2], 2'b00};
  assign bus_wr_o    = wr_q;
  assign bus_be_o    = be_q;
  assign bus_wdata_o = wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;

  assign stall_o = (if_req_i & ~if_rvalid_o) | (d_req_i & ~d_rvalid_o);

endmodule
